// File: rtl/mont_pkg.sv
// Shared constants and state encoding for the Montgomery multiplier and the
// n0prime stage that feeds it. DATA_LENGTH is the operand width both stages
// agree on.
package mont_pkg;

    localparam int WORD_W      = 64;
    localparam int NUM_WORDS   = 64;
    localparam int DATA_LENGTH = WORD_W * NUM_WORDS;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_AB    = 3'd1,
        COMPUTE_M = 3'd2,
        MUL_MN    = 3'd3,
        FINAL_SUB = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Width of a word-index counter; never zero so a one-word build still has a counter.
    function automatic int ctr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mont_mac_word.sv
// Single-word multiply-accumulate: {c_out, s} = x*y + acc + c_in.
// The full 2*WORD_W sum never overflows: (2^W-1)^2 + 2*(2^W-1) = 2^(2W)-1.
// This is the only full word multiplier in the datapath; every phase shares it.
module mont_mac_word
#(
    parameter int WORD_W = mont_pkg::WORD_W
) (
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic [WORD_W-1:0] acc,
    input  logic [WORD_W-1:0] c_in,
    output logic [WORD_W-1:0] s,
    output logic [WORD_W-1:0] c_out
);
    import mont_pkg::*;

    logic [2*WORD_W-1:0] sum;

    // Widen every operand to the product width before adding.
    always_comb begin
        sum   = ({{WORD_W{1'b0}}, x} * {{WORD_W{1'b0}}, y})
              + {{WORD_W{1'b0}}, acc}
              + {{WORD_W{1'b0}}, c_in};
        s     = sum[WORD_W-1:0];
        c_out = sum[2*WORD_W-1:WORD_W];
    end

endmodule

// File: rtl/mont_mul.sv
// Word-serial CIOS Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^DATA_LENGTH.
// Latency is constant: done rises 2*NUM_WORDS^2 + 2*NUM_WORDS + 1 cycles after
// the edge that accepts start.
//
// Handshake: start is sampled only while busy=0 (state IDLE); a start seen while
// busy is dropped, not queued. busy rises the cycle after acceptance and falls in
// the same cycle done pulses. result and err are qualified by the one-cycle done
// pulse and hold their value until the next done.
//
// Optional build macro MONT_N0_CHECK_EN: verifies n[0]*n0prime == -1 mod 2^WORD_W
// in the first busy cycle and, on mismatch, aborts with err=1 and result=0.
// Without the macro err is constant 0.
module mont_mul
#(
    parameter int WORD_W    = mont_pkg::WORD_W,
    parameter int NUM_WORDS = mont_pkg::NUM_WORDS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [WORD_W*NUM_WORDS-1:0] a,
    input  logic [WORD_W*NUM_WORDS-1:0] b,
    input  logic [WORD_W*NUM_WORDS-1:0] n,
    input  logic [WORD_W-1:0]           n0prime,
    output logic [WORD_W*NUM_WORDS-1:0] result,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    import mont_pkg::*;

    localparam int DATA_LENGTH         = WORD_W * NUM_WORDS;
    localparam int CW                  = ctr_width(NUM_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    // FSM state, visible to bound checkers
    state_t state_q, state_d;

    // Captured operands, split into words
    logic [WORD_W-1:0] a_w [NUM_WORDS];
    logic [WORD_W-1:0] b_w [NUM_WORDS];
    logic [WORD_W-1:0] n_w [NUM_WORDS];
    logic [WORD_W-1:0] n0_q;

    // Accumulator t (NUM_WORDS+2 words), candidate difference d, scalars
    logic [WORD_W-1:0] t_q [NUM_WORDS+2];
    logic [WORD_W-1:0] d_w [NUM_WORDS];
    logic [WORD_W-1:0] m_q;
    logic [WORD_W-1:0] c_q;
    logic              bor_q;
    logic [CW-1:0]     i_q, j_q;
    logic              err_flag_q;

    // Combinational helpers
    logic [WORD_W-1:0] a_j, b_i, n_j, t_j;
    logic [WORD_W-1:0] mac_x, mac_y, mac_acc, mac_cin, mac_s, mac_c;
    logic              first_j, last_j, last_i;
    logic              check_fail;
    logic [WORD_W:0]   fold_sum;
    logic [WORD_W:0]   sub_diff;
    logic [DATA_LENGTH-1:0] d_flat, t_flat;

    mont_mac_word #(.WORD_W(WORD_W)) u_mac (
        .x     (mac_x),
        .y     (mac_y),
        .acc   (mac_acc),
        .c_in  (mac_cin),
        .s     (mac_s),
        .c_out (mac_c)
    );

    // Select the words addressed by the inner (j) and outer (i) indices
    always_comb begin
        a_j = '0;
        b_i = '0;
        n_j = '0;
        t_j = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (j_q == CW'(k)) begin
                a_j = a_w[k];
                n_j = n_w[k];
                t_j = t_q[k];
            end
            if (i_q == CW'(k)) begin
                b_i = b_w[k];
            end
        end
    end

    // Carry fold into the top words, borrow-chain subtract, flattened views
    always_comb begin
        fold_sum = {1'b0, t_q[NUM_WORDS]} + {1'b0, mac_c};
        sub_diff = {1'b0, t_j} - {1'b0, n_j}
                 - {{WORD_W{1'b0}}, (first_j ? 1'b0 : bor_q)};
        d_flat = '0;
        t_flat = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            d_flat[k*WORD_W +: WORD_W] = d_w[k];
            t_flat[k*WORD_W +: WORD_W] = t_q[k];
        end
    end

`ifdef MONT_N0_CHECK_EN
    logic [WORD_W-1:0] n0_chk_lo;

    // Low word of n[0]*n0prime must be all ones for a valid n0prime
    always_comb begin
        n0_chk_lo  = n_w[0] * n0_q;
        check_fail = (state_q == MUL_AB) && (i_q == '0) && first_j
                   && (n0_chk_lo != {WORD_W{1'b1}});
    end

    // Remember an aborted operation until its done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            err_flag_q <= 1'b0;
        end else if (check_fail) begin
            err_flag_q <= 1'b1;
        end
    end

    // err is published together with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state_q == DONE) begin
            err <= err_flag_q;
        end
    end
`else
    assign check_fail = 1'b0;
    assign err_flag_q = 1'b0;
    assign err        = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = MUL_AB;
            MUL_AB:    if (check_fail) state_d = DONE;
                       else if (last_j) state_d = COMPUTE_M;
            COMPUTE_M: state_d = MUL_MN;
            MUL_MN:    if (last_j) state_d = last_i ? FINAL_SUB : MUL_AB;
            FINAL_SUB: if (last_j) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM outputs: index decodes and steering of the shared multiplier
    always_comb begin
        first_j = (j_q == '0);
        last_j  = (j_q == LAST_IDX);
        last_i  = (i_q == LAST_IDX);
        mac_x   = '0;
        mac_y   = '0;
        mac_acc = '0;
        mac_cin = '0;
        case (state_q)
            MUL_AB: begin
                mac_x   = a_j;
                mac_y   = b_i;
                mac_acc = t_j;
                mac_cin = first_j ? '0 : c_q;
            end
            COMPUTE_M: begin
                mac_x = t_q[0];
                mac_y = n0_q;
            end
            MUL_MN: begin
                mac_x   = m_q;
                mac_y   = n_j;
                mac_acc = t_j;
                mac_cin = first_j ? '0 : c_q;
            end
            default: ;
        endcase
    end

    // Datapath: capture, accumulate, reduce, subtract, publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                a_w[k] <= '0;
                b_w[k] <= '0;
                n_w[k] <= '0;
                d_w[k] <= '0;
            end
            for (int k = 0; k < NUM_WORDS + 2; k++) begin
                t_q[k] <= '0;
            end
            n0_q   <= '0;
            m_q    <= '0;
            c_q    <= '0;
            bor_q  <= 1'b0;
            i_q    <= '0;
            j_q    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NUM_WORDS; k++) begin
                            a_w[k] <= a[k*WORD_W +: WORD_W];
                            b_w[k] <= b[k*WORD_W +: WORD_W];
                            n_w[k] <= n[k*WORD_W +: WORD_W];
                        end
                        for (int k = 0; k < NUM_WORDS + 2; k++) begin
                            t_q[k] <= '0;
                        end
                        n0_q <= n0prime;
                        i_q  <= '0;
                        j_q  <= '0;
                        c_q  <= '0;
                        busy <= 1'b1;
                    end
                end
                MUL_AB: begin
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        if (j_q == CW'(k)) t_q[k] <= mac_s;
                    end
                    c_q <= mac_c;
                    if (last_j) begin
                        // t[NUM_WORDS+1] is zero here; it only ever holds a carry bit
                        t_q[NUM_WORDS]   <= fold_sum[WORD_W-1:0];
                        t_q[NUM_WORDS+1] <= t_q[NUM_WORDS+1]
                                          + {{(WORD_W-1){1'b0}}, fold_sum[WORD_W]};
                        j_q <= '0;
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end
                COMPUTE_M: begin
                    m_q <= mac_s;
                end
                MUL_MN: begin
                    // Word 0 of t + m*n is zero by choice of m, so each sum lands one word down
                    for (int k = 1; k < NUM_WORDS; k++) begin
                        if (j_q == CW'(k)) t_q[k-1] <= mac_s;
                    end
                    c_q <= mac_c;
                    if (last_j) begin
                        t_q[NUM_WORDS-1] <= fold_sum[WORD_W-1:0];
                        t_q[NUM_WORDS]   <= t_q[NUM_WORDS+1]
                                          + {{(WORD_W-1){1'b0}}, fold_sum[WORD_W]};
                        t_q[NUM_WORDS+1] <= '0;
                        j_q <= '0;
                        i_q <= last_i ? '0 : i_q + CW'(1);
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end
                FINAL_SUB: begin
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        if (j_q == CW'(k)) d_w[k] <= sub_diff[WORD_W-1:0];
                    end
                    bor_q <= sub_diff[WORD_W];
                    j_q   <= last_j ? '0 : j_q + CW'(1);
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    // t >= n when it spills into word NUM_WORDS or the subtract did not borrow
                    if (err_flag_q) begin
                        result <= '0;
                    end else if ((t_q[NUM_WORDS] != '0) || !bor_q) begin
                        result <= d_flat;
                    end else begin
                        result <= t_flat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul.sv
// Self-checking bench for mont_mul with WORD_W=8, NUM_WORDS=2.
// Expected results come from plain modular arithmetic: (a*b mod n) * R^-1 mod n.
`timescale 1ns/1ps
module tb_mont_mul;

    localparam int W      = 8;
    localparam int NW     = 2;
    localparam int DL     = W * NW;
    localparam int LAT    = 2*NW*NW + 2*NW + 1;
    localparam int BUDGET = 200;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic [DL-1:0] a = '0;
    logic [DL-1:0] b = '0;
    logic [DL-1:0] n = '0;
    logic [W-1:0]  n0prime = '0;
    logic [DL-1:0] result;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;
    logic [DL-1:0] exp_q[$];

    always #5 clk = ~clk;

    mont_mul #(.WORD_W(W), .NUM_WORDS(NW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .n       (n),
        .n0prime (n0prime),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint r_inv(input longint nn);
        longint r;
        r = longint'(1) << DL;
        for (longint x = 1; x < nn; x++) begin
            if (((r % nn) * x) % nn == 1) return x;
        end
        return 0;
    endfunction

    function automatic logic [DL-1:0] mont_ref(input longint aa, input longint bb, input longint nn);
        longint p;
        p = (aa * bb) % nn;
        return DL'((p * r_inv(nn)) % nn);
    endfunction

    function automatic logic [W-1:0] n0_ref(input longint nn);
        for (int k = 0; k < (1 << W); k++) begin
            if (((nn * k) & ((1 << W) - 1)) == (1 << W) - 1) return W'(k);
        end
        return '0;
    endfunction

    // ---------------- driver tasks ----------------
    // Launch one operation from a point away from the clock edge, follow it to done.
    // poke > 0 re-asserts start (with junk operands) at that cycle while busy.
    task automatic run_op(input logic [DL-1:0] ta, input logic [DL-1:0] tbv,
                          input logic [DL-1:0] tn, input logic [W-1:0] tn0,
                          input int poke, input bit exp_err);
        int   lat;
        bit   seen;
        bit   busy_ok;
        logic [DL-1:0] expv;
        lat = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        a = ta; b = tbv; n = tn; n0prime = tn0; start = 1'b1;
        exp_q.push_back(exp_err ? '0 : mont_ref(ta, tbv, tn));
        @(posedge clk); #1;
        start = 1'b0;
        // Inputs changing after capture must not matter
        a = DL'($urandom); b = DL'($urandom); n = DL'($urandom); n0prime = W'($urandom);
        for (int k = 1; k <= BUDGET && !seen; k++) begin
            if (k == poke) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_during", 64'(busy_ok), 64'd1);
        check("latency", 64'(lat), exp_err ? 64'd2 : 64'(LAT));
        check("busy_at_done", 64'(busy), 64'd0);
        expv = exp_q.pop_front();
        check("result", 64'(result), 64'(expv));
        check("err", 64'(err), 64'(exp_err));
    endtask

    task automatic idle_watch(input int cycles, input string tag);
        int pulses;
        pulses = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check(tag, 64'(pulses), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DL-1:0] rn, ra, rb;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", 64'(result), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with the fixed bench modulus
        run_op(16'h0019, 16'h0064, 16'h00FB, 8'hCD, 0, 1'b0);
        check("spec_r_times_b", 64'(result), 64'h0064);
        run_op(16'h00FA, 16'h00FA, 16'h00FB, 8'hCD, 0, 1'b0);
        check("spec_final_sub", 64'(result), 64'h00F1);
        run_op(16'h0019, 16'h0019, 16'h00FB, 8'hCD, 0, 1'b0);
        check("spec_r_squared", 64'(result), 64'h0019);
        run_op(16'h0000, 16'h00AB, 16'h00FB, 8'hCD, 0, 1'b0);
        check("spec_zero", 64'(result), 64'h0000);

        // start while busy is ignored and not queued
        run_op(16'h0019, 16'h0064, 16'h00FB, 8'hCD, 5, 1'b0);
        check("busy_start_ignored", 64'(result), 64'h0064);
        idle_watch(20, "no_queued_done");

        // Back-to-back: second start right after done
        run_op(16'h00FA, 16'h00FA, 16'h00FB, 8'hCD, 0, 1'b0);
        run_op(16'h0019, 16'h0064, 16'h00FB, 8'hCD, 0, 1'b0);
        check("back_to_back", 64'(result), 64'h0064);

        // Reset in the middle of an operation
        a = 16'h00FA; b = 16'h00FA; n = 16'h00FB; n0prime = 8'hCD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        idle_watch(20, "no_done_after_abort");
        run_op(16'h00FA, 16'h00FA, 16'h00FB, 8'hCD, 0, 1'b0);
        check("after_abort", 64'(result), 64'h00F1);

`ifdef MONT_N0_CHECK_EN
        run_op(16'h0019, 16'h0064, 16'h00FB, 8'h00, 0, 1'b1);
        check("bad_n0_result", 64'(result), 64'd0);
        run_op(16'h0019, 16'h0064, 16'h00FB, 8'hCD, 0, 1'b0);
`endif

        // Random moduli and operands, including the a=b=n-1 corner
        for (int r = 0; r < 20; r++) begin
            rn = DL'($urandom_range(1, (1 << (DL - 1)) - 1) * 2 + 1);
            ra = DL'($urandom_range(0, int'(rn) - 1));
            rb = DL'($urandom_range(0, int'(rn) - 1));
            run_op(ra, rb, rn, n0_ref(longint'(rn)), 0, 1'b0);
            if (r % 4 == 0) begin
                run_op(rn - 1'b1, rn - 1'b1, rn, n0_ref(longint'(rn)), 0, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mont_mul.md
Name: mont_mul

Overview:
- Word-serial Montgomery multiplier (CIOS) for the RSA decryption datapath.
- Computes result = a*b*R^-1 mod n, with R = 2^(WORD_W*NUM_WORDS).
- Directly consumes n0prime (= -n^-1 mod 2^WORD_W) produced by the upstream n0prime stage, plus the modulus n.
- Repeated invocations by the exponentiation controller implement modular exponentiation.

Parameters:
WORD_W, 64, word width; width of n0prime and of the single internal WORD_W x WORD_W multiplier
NUM_WORDS, 64, operand length in words (4096/64)
DATA_LENGTH, WORD_W*NUM_WORDS, operand width in bits (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request; sampled only when busy=0
a  in  DATA_LENGTH  multiplicand; caller guarantees a < n
b  in  DATA_LENGTH  multiplier; caller guarantees b < n
n  in  DATA_LENGTH  odd modulus
n0prime  in  WORD_W  -n^-1 mod 2^WORD_W from upstream stage
result  out  DATA_LENGTH  a*b*R^-1 mod n, always < n; held until next done
busy  out  1  high from the cycle after start is accepted until done
done  out  1  1-cycle pulse when result is valid
err  out  1  valid with done; see Optional Feature

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; result, busy, done, err = 0; internal t and counters cleared.
  - Reset mid-operation aborts the operation; no done pulse is issued.
- Operand capture: at start in IDLE, a, b, n and n0prime are latched. Later input changes have no effect.
- start while busy=1 is ignored; it is not queued.
- Internal accumulator t: NUM_WORDS+2 words. i = outer word index, j = inner word index.
- States and transitions:
  - IDLE: on start -> MUL_AB; i=0, j=0, t=0, busy=1.
  - MUL_AB: NUM_WORDS cycles. Each cycle: {C,t[j]} = t[j] + a[j]*b[i] + C. On the last cycle the carry is folded into t[NUM_WORDS] and t[NUM_WORDS+1]. -> COMPUTE_M.
  - COMPUTE_M: 1 cycle. m = (t[0]*n0prime) mod 2^WORD_W. -> MUL_MN.
  - MUL_MN: NUM_WORDS cycles. Each cycle: {C,s} = t[j] + m*n[j] + C; s is written to t[j-1]. The j=0 word is discarded because it is zero by construction. On the last cycle the top words are propagated and shifted down one word. Then i++: if i<NUM_WORDS -> MUL_AB; else -> FINAL_SUB.
  - FINAL_SUB: NUM_WORDS cycles. Word-serial computation of d = t - n with borrow. If t[NUM_WORDS]=1 or the final borrow is 0, result=d; else result=t[NUM_WORDS-1:0]. -> DONE.
  - DONE: 1 cycle. done=1, busy=0. -> IDLE.
- Latency: done is high exactly LAT = 2*NUM_WORDS^2 + 2*NUM_WORDS + 1 cycles after the start edge (41 for NUM_WORDS=4). Latency is data-independent (constant-time).
- Arithmetic: all word products are 2*WORD_W bits. Carries are WORD_W+1 bits maximum. Nothing is truncated until the final selection.
- Boundary: a=0 or b=0 gives result=0 with full latency. a=n-1, b=n-1 must exercise the final-subtract path without overflow.

Optional Feature:
MONT_N0_CHECK_EN
- Defined:
  - In the cycle after start is accepted, check (n[WORD_W-1:0]*n0prime) mod 2^WORD_W == all-ones.
  - On failure: skip computation, go to DONE; done pulses 2 cycles after start, err=1, result=0.
  - This guards against a bad n0prime from upstream (e.g. operand ordering misuse).
- Undefined: no check is performed; err is tied to 0.

Decomposition:
- Shared package (mont_pkg): WORD_W, NUM_WORDS, DATA_LENGTH constants; state encoding (IDLE, MUL_AB, COMPUTE_M, MUL_MN, FINAL_SUB, DONE).
- The same DATA_LENGTH constant is shared with the n0prime stage.
- One natural sub-module: mont_mac_word. It is combinational WORD_W: {c_out,s} = x*y + acc + c_in. It is used by both MUL_AB and MUL_MN, so only one multiplier is instantiated.

Test Plan:
Bench config: WORD_W=8, NUM_WORDS=2, n=0x00FB, n0prime=0xCD. R mod n = 0x0019; R^-1 mod n = 0x00F1.
- a=0x0019, b=0x0064, start -> result=0x0064; done exactly 13 cycles after start; busy high in between.
- a=0x00FA, b=0x00FA -> result=0x00F1 (final-subtract path); a=0x0019, b=0x0019 -> result=0x0019.
- a=0x0000, b=0x00AB -> result=0x0000 with full 13-cycle latency; err=0.
- start pulsed again at cycle 5 while busy -> ignored; single done at cycle 13 with the first operation's result. Back-to-back start on the cycle after done is accepted.
- rst_n low at cycle 6 of an operation -> busy, done, result = 0 immediately; no done pulse; a fresh start afterwards gives the correct result.
- With MONT_N0_CHECK_EN, n0prime=0x00 -> done 2 cycles after start, err=1, result=0. With n0prime=0xCD -> err=0.
